// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared state encoding and block geometry for the cache memory arbiter
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_FILL  = 2'd1,
        ST_D_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } arb_state_e;

    localparam int BLOCK_WORDS = 8;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = $clog2(BLOCK_WORDS);

endpackage

// File: rtl/arb_beat_counter.sv
// rtl/arb_beat_counter.sv - block word counter with a sticky done flag once all words are counted
module arb_beat_counter
    import cache_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (inc && !done_q) begin
            // count wraps to zero on the last word; done keeps the block closed
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(BLOCK_WORDS - 1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - arbitrates I/D cache block fills and D-cache write-through stores onto one memory port
module cache_mem_arbiter
    import cache_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_mem_addr,
    input  logic        d_miss,
    input  logic [15:0] d_mem_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        mem_data_valid,
    output logic        i_grant,
    output logic        d_grant,
    output logic        i_mem_valid,
    output logic        d_mem_valid,
    output logic        d_wr_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        busy
);

    arb_state_e       state_q, state_d;
    logic             fair_q, fair_d;
    logic             in_fill;
    logic             issuing;
    logic             issue_done;
    logic             beat_inc;
    logic             beat_done;
    logic             last_beat;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] issue_idx_unused;

    assign in_fill   = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
    assign issuing   = in_fill && !issue_done;
    assign beat_inc  = in_fill && mem_data_valid && !beat_done;
    assign last_beat = beat_inc && (beat_cnt == CNT_W'(BLOCK_WORDS - 1));

    arb_beat_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_fill),
        .inc   (issuing),
        .count (issue_idx_unused),
        .done  (issue_done)
    );

    arb_beat_counter u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_fill),
        .inc   (beat_inc),
        .count (beat_cnt),
        .done  (beat_done)
    );

    always_comb begin
        state_d = state_q;
        fair_d  = fair_q;
        unique case (state_q)
            ST_IDLE: begin
                // a starved I-side miss jumps the queue once after a D fill
                if (fair_q && i_miss) begin
                    state_d = ST_I_FILL;
                end else if (d_wr_req) begin
                    state_d = ST_D_WRITE;
                end else if (d_miss) begin
                    state_d = ST_D_FILL;
                end else if (i_miss) begin
                    state_d = ST_I_FILL;
                end
            end
            ST_I_FILL, ST_D_FILL: begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            ST_D_WRITE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (state_q == ST_D_FILL && last_beat && i_miss) begin
            fair_d = 1'b1;
        end
        if (state_q == ST_IDLE && state_d == ST_I_FILL) begin
            fair_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fair_q  <= fair_d;
        end
    end

    always_comb begin
        i_grant     = (state_q == ST_I_FILL);
        d_grant     = (state_q == ST_D_FILL);
        i_mem_valid = mem_data_valid && i_grant;
        d_mem_valid = mem_data_valid && d_grant;
        d_wr_done   = (state_q == ST_D_WRITE);
        mem_wr      = (state_q == ST_D_WRITE);
        mem_en      = issuing || mem_wr;
        busy        = (state_q != ST_IDLE);
        mem_addr    = 16'h0000;
        mem_data_in = 16'h0000;
        if (issuing) begin
            mem_addr = i_grant ? i_mem_addr : d_mem_addr;
        end else if (mem_wr) begin
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed and random stimulus against a transaction-level arbiter model
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, i_miss, d_miss, d_wr_req, mem_data_valid;
    logic [15:0] i_mem_addr, d_mem_addr, d_wr_addr, d_wr_data;
    logic        i_grant, d_grant, i_mem_valid, d_mem_valid, d_wr_done, mem_en, mem_wr, busy;
    logic [15:0] mem_addr, mem_data_in;
    logic [7:0]  ctl_obs;

    localparam int OWN_NONE = 0, OWN_I = 1, OWN_D = 2, OWN_W = 3;

    int          m_own, m_age, m_beats;
    bit          m_fair;
    logic [3:0]  rd_pipe;
    bit          stray;
    logic [15:0] i_base, d_base;
    int          n_vec, n_err;
    int          n_busy, n_ibeat, n_dbeat, n_en, n_wr, n_done, prev_obs;
    logic [15:0] wr_addr_seen, wr_data_seen;
    int          glog[$];

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst), .i_miss(i_miss), .i_mem_addr(i_mem_addr),
        .d_miss(d_miss), .d_mem_addr(d_mem_addr), .d_wr_req(d_wr_req),
        .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .mem_data_valid(mem_data_valid),
        .i_grant(i_grant), .d_grant(d_grant), .i_mem_valid(i_mem_valid),
        .d_mem_valid(d_mem_valid), .d_wr_done(d_wr_done), .mem_en(mem_en),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .busy(busy)
    );

    assign ctl_obs = {busy, i_grant, d_grant, i_mem_valid, d_mem_valid, d_wr_done, mem_en, mem_wr};

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int log_code();
        int c = 0;
        for (int k = 0; k < glog.size(); k++) c |= glog[k] << (4 * k);
        return c;
    endfunction

    task automatic clr_obs();
        n_busy = 0; n_ibeat = 0; n_dbeat = 0; n_en = 0; n_wr = 0; n_done = 0;
        prev_obs = OWN_NONE; glog.delete();
        wr_addr_seen = 16'h0; wr_data_seen = 16'h0;
    endtask

    // entered just after a rising edge; checks mid-cycle, then advances the model on the next edge
    task automatic tick();
        bit          fill, iss;
        logic [7:0]  e_ctl;
        logic [15:0] e_addr, e_wdata;
        int          obs;
        fill = (m_own == OWN_I) || (m_own == OWN_D);
        i_mem_addr = i_base + 16'(2 * ((m_own == OWN_I) ? m_age : 0));
        d_mem_addr = d_base + 16'(2 * ((m_own == OWN_D) ? m_age : 0));
        mem_data_valid = rd_pipe[3] | (stray & !fill);
        #4;
        iss = fill && (m_age < 8);
        e_ctl = {m_own != OWN_NONE, m_own == OWN_I, m_own == OWN_D,
                 mem_data_valid && m_own == OWN_I, mem_data_valid && m_own == OWN_D,
                 m_own == OWN_W, iss || m_own == OWN_W, m_own == OWN_W};
        e_addr  = iss ? ((m_own == OWN_I) ? i_mem_addr : d_mem_addr)
                      : ((m_own == OWN_W) ? d_wr_addr : 16'h0);
        e_wdata = (m_own == OWN_W) ? d_wr_data : 16'h0;
        expect_eq("ctl", {24'h0, ctl_obs}, {24'h0, e_ctl});
        expect_eq("mem_addr", {16'h0, mem_addr}, {16'h0, e_addr});
        expect_eq("mem_data_in", {16'h0, mem_data_in}, {16'h0, e_wdata});
        if (busy) n_busy++;
        if (i_mem_valid) n_ibeat++;
        if (d_mem_valid) n_dbeat++;
        if (mem_en && !mem_wr) n_en++;
        if (mem_wr) begin n_wr++; wr_addr_seen = mem_addr; wr_data_seen = mem_data_in; end
        if (d_wr_done) n_done++;
        obs = i_grant ? OWN_I : d_grant ? OWN_D : d_wr_done ? OWN_W : OWN_NONE;
        if (obs != OWN_NONE && obs != prev_obs) glog.push_back(obs);
        prev_obs = obs;
        @(posedge clk);
        rd_pipe = {rd_pipe[2:0], iss};
        if (rst) begin
            m_own = OWN_NONE; m_age = 0; m_beats = 0; m_fair = 0;
        end else begin
            case (m_own)
                OWN_NONE: begin
                    m_age = 0; m_beats = 0;
                    if (m_fair && i_miss) begin m_own = OWN_I; m_fair = 0; end
                    else if (d_wr_req) m_own = OWN_W;
                    else if (d_miss) m_own = OWN_D;
                    else if (i_miss) begin m_own = OWN_I; m_fair = 0; end
                end
                OWN_I, OWN_D: begin
                    m_age++;
                    if (mem_data_valid) m_beats++;
                    if (m_beats == 8) begin
                        if (m_own == OWN_D && i_miss) m_fair = 1;
                        m_own = OWN_NONE;
                    end
                end
                default: m_own = OWN_NONE;
            endcase
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_own = OWN_NONE; m_age = 0; m_beats = 0; m_fair = 0;
        rd_pipe = 4'h0; stray = 0; i_base = 16'h0; d_base = 16'h0;
        rst = 1; i_miss = 0; d_miss = 0; d_wr_req = 0; mem_data_valid = 0;
        i_mem_addr = 16'h0; d_mem_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        clr_obs();
        @(posedge clk); #1;
        run(2);
        expect_eq("reset_ctl", {24'h0, ctl_obs}, 32'h0);
        expect_eq("reset_bus", {mem_addr, mem_data_in}, 32'h0);
        rst = 0;
        run(2);

        // single I fill with a stepping address
        clr_obs(); i_base = 16'h0100; i_miss = 1; tick(); i_miss = 0; run(16);
        expect_eq("i_fill_busy", n_busy, 12);
        expect_eq("i_fill_reads", n_en, 8);
        expect_eq("i_fill_beats", n_ibeat, 8);
        expect_eq("i_fill_order", log_code(), OWN_I);

        // simultaneous misses: D first, then I by fairness despite a pending D miss
        clr_obs(); d_base = 16'h0200; i_base = 16'h0200; i_miss = 1; d_miss = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (m_own == OWN_I) begin i_miss = 0; d_miss = 0; end
        end
        expect_eq("fair_order", log_code(), OWN_D | (OWN_I << 4));
        expect_eq("fair_busy", n_busy, 24);

        // store with a concurrent D miss
        clr_obs(); d_wr_addr = 16'h0300; d_wr_data = 16'hDEAD; d_wr_req = 1; d_miss = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (m_own == OWN_W) d_wr_req = 0;
            if (m_own == OWN_D) d_miss = 0;
        end
        expect_eq("wr_order", log_code(), OWN_W | (OWN_D << 4));
        expect_eq("wr_cycles", n_wr, 1);
        expect_eq("wr_done_pulses", n_done, 1);
        expect_eq("wr_addr", {16'h0, wr_addr_seen}, 32'h0000_0300);
        expect_eq("wr_data", {16'h0, wr_data_seen}, 32'h0000_DEAD);
        expect_eq("wr_fill_beats", n_dbeat, 8);
        d_wr_addr = 16'h0; d_wr_data = 16'h0;

        // reset after the third beat of a D fill; late beats must be ignored
        clr_obs(); d_miss = 1;
        for (int k = 0; k < 30 && n_dbeat < 3; k++) tick();
        expect_eq("rst_mid_beats", n_dbeat, 3);
        d_miss = 0; rst = 1; tick(); rst = 0;
        expect_eq("rst_mid_ctl", {24'h0, ctl_obs}, 32'h0);
        clr_obs(); run(8);
        expect_eq("rst_late_beats", n_ibeat + n_dbeat, 0);
        expect_eq("rst_late_busy", n_busy, 0);

        // D miss dropped after two beats, then stray valids while idle
        clr_obs(); d_base = 16'h0400; d_miss = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (n_dbeat >= 2) d_miss = 0;
        end
        expect_eq("drop_beats", n_dbeat, 8);
        expect_eq("drop_busy", n_busy, 12);
        clr_obs(); stray = 1; run(5); stray = 0;
        expect_eq("stray_beats", n_ibeat + n_dbeat, 0);
        expect_eq("stray_busy", n_busy, 0);

        for (int k = 0; k < 600; k++) begin
            i_miss    = ($urandom_range(2) == 0);
            d_miss    = ($urandom_range(3) == 0);
            d_wr_req  = ($urandom_range(5) == 0);
            rst       = ($urandom_range(149) == 0);
            stray     = ($urandom_range(1) == 0);
            i_base    = 16'($urandom);
            d_base    = 16'($urandom);
            d_wr_addr = 16'($urandom);
            d_wr_data = 16'($urandom);
            tick();
        end
        rst = 0; i_miss = 0; d_miss = 0; d_wr_req = 0; stray = 0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
